fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the 2A03 control FSM. Owns the program counter, reads the reset vector after reset, then fetches each opcode plus its 0–2 operand bytes from synchronous memory. It presents a complete instruction (`ir`, operand bytes, next-PC) to the control block with a valid/ready handshake. The control block redirects the PC for jumps, branches and interrupts through a load port.

## Interface
Parameters:
- `RESET_VEC`, 16'hFFFC: address of the reset vector low byte; the high byte is at `RESET_VEC+1`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` out 16: fetch address.
- `mem_rd` out 1: read strobe; `mem_rdata` is valid on the cycle after the strobe.
- `mem_rdata` in 8: read data.
- `ir` out 8: opcode; feeds the control block's `IR`.
- `opr_lo` out 8: first operand byte.
- `opr_hi` out 8: second operand byte.
- `len` out 2: instruction length, 1 to 3 bytes.
- `pc_next` out 16: address of the byte following the instruction.
- `instr_valid` out 1: instruction bundle is stable.
- `instr_ready` in 1: control block consumes the bundle.
- `pc_load` in 1: redirect request.
- `pc_in` in 16: redirect target.
- `illegal` out 1: undocumented opcode; exists only with `FETCH_ILLEGAL_TRAP_EN`.

## Operation
- FSM states: `VEC_LO`, `VEC_HI`, `VEC_CAP`, `FETCH_OP`, `DEC`, `OPL`, `OPH`, `VALID`.
- `VEC_LO`: `mem_addr=RESET_VEC`, `mem_rd=1`. Next state `VEC_HI`.
- `VEC_HI`: `mem_addr=RESET_VEC+1`, `mem_rd=1`. Capture `mem_rdata` into PC[7:0]. Next state `VEC_CAP`.
- `VEC_CAP`: capture `mem_rdata` into PC[15:8]. Next state `FETCH_OP`.
- `FETCH_OP`: `mem_addr=PC`, `mem_rd=1`, PC increments. Next state `DEC`.
- `DEC`:
  - Capture `mem_rdata` into `ir`.
  - Look up the length L in the package table.
  - If L=1, go to `VALID`.
  - Otherwise issue a read at PC, increment PC, and go to `OPL`.
- `OPL`:
  - Capture `mem_rdata` into `opr_lo`.
  - If L=3, issue a read at PC, increment PC, and go to `OPH`.
  - Otherwise go to `VALID`.
- `OPH`: capture `mem_rdata` into `opr_hi`. Next state `VALID`.
- `VALID`:
  - `instr_valid=1`. The bundle and PC are frozen while `instr_ready=0`.
  - On `instr_ready=1`: if `pc_load=1`, PC←`pc_in`; otherwise PC is unchanged. Next state `FETCH_OP`.
- `pc_load` is honoured only in `VALID` with `instr_ready=1`; it is ignored in every other state.
- Operand bytes not fetched for the current instruction are cleared to 8'h00 in `DEC`.
- `pc_next` always equals the live PC. In `VALID` that is the instruction address plus `len`.
- PC arithmetic is 16-bit modulo: FFFF+1 wraps to 0000, with no flag.
- Length table is the documented MOS 6502 set. Under this block's convention BRK (00), RTI (40) and RTS (60) are length 1.

## Timing
- Reset values:
  - State `VEC_LO`.
  - PC=16'h0000.
  - `ir`=8'hEA (NOP).
  - `opr_lo`=8'h00, `opr_hi`=8'h00.
  - `len`=1.
  - `instr_valid`=0, `illegal`=0.
- Combinational outputs in the reset cycle: `mem_rd`=0 and `mem_addr`=16'h0000.
- First `instr_valid` appears 6/7/8 cycles after `rst` deasserts, for length 1/2/3.
- Steady state: `FETCH_OP` to `VALID` takes L+1 cycles. The handshake costs 1 cycle, so throughput is one instruction per L+2 cycles.
- `mem_rd` is asserted at most once per cycle. Exactly one read is outstanding after each strobe.
- `rst` in any state, including mid-instruction or while `VALID` is stalled, returns to `VEC_LO` on the next edge. Any in-flight read data is discarded.
- `instr_ready` outside `VALID` has no effect.

## Configuration
- `FETCH_ILLEGAL_TRAP_EN` defined:
  - Undocumented opcodes take length 1 and assert `illegal=1` together with `instr_valid`.
  - `illegal` clears on the handshake.
- Macro undefined:
  - The `illegal` port is absent.
  - Undocumented opcodes issue as length-1 instructions, and the control block treats them as NOP.

## Structure
- Shared package `cpu_pkg` holds:
  - The 256-entry opcode length constant (2 bits per entry).
  - The 256-bit documented-opcode mask.
  - The FSM state enum.
  - `RESET_VEC`.
- One sub-module, `opcode_len_rom`: combinational lookup from opcode to {`len`, `legal`}. It is reused later by the disassembly monitor.

## Test plan
- Reset vector: memory FFFC=34, FFFD=12, 1234=EA → `instr_valid` 6 cycles after reset. Expect `ir`=EA, `len`=1, `pc_next`=1235.
- Three-byte instruction: 1234=AD 00 02 → `ir`=AD, `opr_lo`=00, `opr_hi`=02, `len`=3, `pc_next`=1237, valid 8 cycles after reset.
- Stall: hold `instr_ready`=0 for 10 cycles in `VALID` → bundle stable, `mem_rd`=0 throughout. Raise `instr_ready` → `mem_addr`=`pc_next` on the next cycle.
- Redirect: `pc_load`=1, `pc_in`=8000 with ready on A9 05 → next fetch address is 8000. A `pc_load` pulse during `OPL` is ignored.
- Wrap: PC=FFFE, bytes A9 07 → `opr_lo`=07, `pc_next`=0000.
- Reset mid-fetch: assert `rst` in `OPH` → next cycle state is `VEC_LO` and `instr_valid`=0. With `FETCH_ILLEGAL_TRAP_EN`, opcode 02 gives `illegal`=1, `len`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared 2A03 front-end definitions: fetch FSM states, reset vector address,
// and the documented-6502 opcode length table and legality mask.
package cpu_pkg;

    localparam logic [15:0] RESET_VEC = 16'hFFFC;

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, VEC_CAP, FETCH_OP, DEC, OPL, OPH, VALID
    } fetch_state_t;

    // {legal, len}; BRK, RTI and RTS are treated as single-byte instructions.
    function automatic logic [2:0] op_info(input logic [7:0] op);
        case (op)
            8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E, 8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h39,
            8'h3D, 8'h3E, 8'h4C, 8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E, 8'h6C, 8'h6D,
            8'h6E, 8'h79, 8'h7D, 8'h7E, 8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D, 8'hAC,
            8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE, 8'hCC, 8'hCD, 8'hCE, 8'hD9,
            8'hDD, 8'hDE, 8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE:
                op_info = {1'b1, 2'd3};
            8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16, 8'h21, 8'h24,
            8'h25, 8'h26, 8'h29, 8'h30, 8'h31, 8'h35, 8'h36, 8'h41, 8'h45, 8'h46,
            8'h49, 8'h50, 8'h51, 8'h55, 8'h56, 8'h61, 8'h65, 8'h66, 8'h69, 8'h70,
            8'h71, 8'h75, 8'h76, 8'h81, 8'h84, 8'h85, 8'h86, 8'h90, 8'h91, 8'h94,
            8'h95, 8'h96, 8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9, 8'hB0,
            8'hB1, 8'hB4, 8'hB5, 8'hB6, 8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC9,
            8'hD0, 8'hD1, 8'hD5, 8'hD6, 8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9,
            8'hF0, 8'hF1, 8'hF5, 8'hF6:
                op_info = {1'b1, 2'd2};
            8'h00, 8'h08, 8'h0A, 8'h18, 8'h28, 8'h2A, 8'h38, 8'h40, 8'h48, 8'h4A,
            8'h58, 8'h60, 8'h68, 8'h6A, 8'h78, 8'h88, 8'h8A, 8'h98, 8'h9A, 8'hA8,
            8'hAA, 8'hB8, 8'hBA, 8'hC8, 8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8:
                op_info = {1'b1, 2'd1};
            default:
                op_info = {1'b0, 2'd1};
        endcase
    endfunction

    function automatic logic [511:0] build_len_table();
        logic [511:0] t;
        logic [2:0]   e;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            e = op_info(8'(i));
            t[2*i +: 2] = e[1:0];
        end
        return t;
    endfunction

    function automatic logic [255:0] build_legal_mask();
        logic [255:0] m;
        logic [2:0]   e;
        m = '0;
        for (int i = 0; i < 256; i++) begin
            e = op_info(8'(i));
            m[i] = e[2];
        end
        return m;
    endfunction

    localparam logic [511:0] OP_LEN_TABLE  = build_len_table();
    localparam logic [255:0] OP_LEGAL_MASK = build_legal_mask();

endpackage

// File: rtl/opcode_len_rom.sv
// Combinational opcode lookup returning instruction length and documented flag.
module opcode_len_rom
    import cpu_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_len,
    output logic       o_legal
);

    assign o_len   = OP_LEN_TABLE[{i_opcode, 1'b0} +: 2];
    assign o_legal = OP_LEGAL_MASK[i_opcode];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads the reset vector, fetches opcode plus operands, and
// hands a complete bundle to the control FSM. FETCH_ILLEGAL_TRAP_EN adds the illegal flag.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = cpu_pkg::RESET_VEC
) (
    input  logic         clk,
    input  logic         rst,
    output logic [15:0]  mem_addr,
    output logic         mem_rd,
    input  logic [7:0]   mem_rdata,
    output logic [7:0]   ir,
    output logic [7:0]   opr_lo,
    output logic [7:0]   opr_hi,
    output logic [1:0]   len,
    output logic [15:0]  pc_next,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         pc_load,
    input  logic [15:0]  pc_in,
`ifdef FETCH_ILLEGAL_TRAP_EN
    output logic         illegal,
`endif
    output fetch_state_t dbg_state
);

    fetch_state_t r_state, w_state_nxt;
    logic [15:0]  r_pc, w_pc_nxt, w_pc_inc;
    logic [7:0]   r_ir, w_ir_nxt, r_opr_lo, w_opr_lo_nxt, r_opr_hi, w_opr_hi_nxt;
    logic [1:0]   r_len, w_len_nxt, w_rom_len, w_dec_len;
    logic         w_rom_legal;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic         r_illegal, w_illegal_nxt;
`endif

    opcode_len_rom u_len_rom (
        .i_opcode (mem_rdata),
        .o_len    (w_rom_len),
        .o_legal  (w_rom_legal)
    );

    assign w_dec_len = w_rom_legal ? w_rom_len : 2'd1;
    assign w_pc_inc  = r_pc + 16'd1;

    // Handshake: the bundle is held stable while instr_valid=1; it transfers on the
    // rising edge where instr_ready=1, which is also the only edge pc_load is honoured.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_opr_lo_nxt = r_opr_lo;
        w_opr_hi_nxt = r_opr_hi;
        w_len_nxt    = r_len;
`ifdef FETCH_ILLEGAL_TRAP_EN
        w_illegal_nxt = r_illegal;
`endif
        mem_addr     = 16'h0000;
        mem_rd       = 1'b0;
        case (r_state)
            VEC_LO: begin
                mem_addr    = RESET_VEC;
                mem_rd      = 1'b1;
                w_state_nxt = VEC_HI;
            end
            VEC_HI: begin
                mem_addr    = RESET_VEC + 16'd1;
                mem_rd      = 1'b1;
                w_pc_nxt    = {r_pc[15:8], mem_rdata};
                w_state_nxt = VEC_CAP;
            end
            VEC_CAP: begin
                w_pc_nxt    = {mem_rdata, r_pc[7:0]};
                w_state_nxt = FETCH_OP;
            end
            FETCH_OP: begin
                mem_addr    = r_pc;
                mem_rd      = 1'b1;
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = DEC;
            end
            DEC: begin
                w_ir_nxt     = mem_rdata;
                w_len_nxt    = w_dec_len;
                w_opr_lo_nxt = 8'h00;
                w_opr_hi_nxt = 8'h00;
`ifdef FETCH_ILLEGAL_TRAP_EN
                w_illegal_nxt = ~w_rom_legal;
`endif
                if (w_dec_len == 2'd1) begin
                    w_state_nxt = VALID;
                end else begin
                    mem_addr    = r_pc;
                    mem_rd      = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = OPL;
                end
            end
            OPL: begin
                w_opr_lo_nxt = mem_rdata;
                if (r_len == 2'd3) begin
                    mem_addr    = r_pc;
                    mem_rd      = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = OPH;
                end else begin
                    w_state_nxt = VALID;
                end
            end
            OPH: begin
                w_opr_hi_nxt = mem_rdata;
                w_state_nxt  = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    w_pc_nxt    = pc_load ? pc_in : r_pc;
                    w_state_nxt = FETCH_OP;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    w_illegal_nxt = 1'b0;
`endif
                end
            end
            default: w_state_nxt = VEC_LO;
        endcase
        // No memory traffic while reset is held, so in-flight reads are simply dropped.
        if (rst) begin
            mem_addr = 16'h0000;
            mem_rd   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= VEC_LO;
            r_pc     <= 16'h0000;
            r_ir     <= 8'hEA;
            r_opr_lo <= 8'h00;
            r_opr_hi <= 8'h00;
            r_len    <= 2'd1;
`ifdef FETCH_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_opr_lo <= w_opr_lo_nxt;
            r_opr_hi <= w_opr_hi_nxt;
            r_len    <= w_len_nxt;
`ifdef FETCH_ILLEGAL_TRAP_EN
            r_illegal <= w_illegal_nxt;
`endif
        end
    end

    assign ir          = r_ir;
    assign opr_lo      = r_opr_lo;
    assign opr_hi      = r_opr_hi;
    assign len         = r_len;
    assign pc_next     = r_pc;
    assign instr_valid = (r_state == VALID);
    assign dbg_state   = r_state;
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign illegal     = r_illegal;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous memory model, directed scenarios and a randomized
// program walk checked against a reference bundle model through an expected queue.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  mem_addr;
    logic         mem_rd;
    logic [7:0]   mem_rdata = 8'h00;
    logic [7:0]   ir, opr_lo, opr_hi;
    logic [1:0]   len;
    logic [15:0]  pc_next;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic         pc_load = 1'b0;
    logic [15:0]  pc_in = 16'h0000;
    fetch_state_t dbg_state;
    logic         illegal_w;

    fetch_unit #(.RESET_VEC(16'hFFFC)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .opr_lo      (opr_lo),
        .opr_hi      (opr_hi),
        .len         (len),
        .pc_next     (pc_next),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
`ifdef FETCH_ILLEGAL_TRAP_EN
        .illegal     (illegal_w),
`endif
        .dbg_state   (dbg_state)
    );
`ifndef FETCH_ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [65536];
    always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]  ir;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [1:0]  len;
        logic [15:0] pcn;
        logic        ill;
    } bundle_t;

    logic [1:0] ref_len   [256];
    logic       ref_legal [256];
    logic [7:0] ops3 [48] = '{8'h0D,8'h0E,8'h19,8'h1D,8'h1E,8'h20,8'h2C,8'h2D,8'h2E,8'h39,
        8'h3D,8'h3E,8'h4C,8'h4D,8'h4E,8'h59,8'h5D,8'h5E,8'h6C,8'h6D,8'h6E,8'h79,8'h7D,8'h7E,
        8'h8C,8'h8D,8'h8E,8'h99,8'h9D,8'hAC,8'hAD,8'hAE,8'hB9,8'hBC,8'hBD,8'hBE,8'hCC,8'hCD,
        8'hCE,8'hD9,8'hDD,8'hDE,8'hEC,8'hED,8'hEE,8'hF9,8'hFD,8'hFE};
    logic [7:0] ops2 [74] = '{8'h01,8'h05,8'h06,8'h09,8'h10,8'h11,8'h15,8'h16,8'h21,8'h24,
        8'h25,8'h26,8'h29,8'h30,8'h31,8'h35,8'h36,8'h41,8'h45,8'h46,8'h49,8'h50,8'h51,8'h55,
        8'h56,8'h61,8'h65,8'h66,8'h69,8'h70,8'h71,8'h75,8'h76,8'h81,8'h84,8'h85,8'h86,8'h90,
        8'h91,8'h94,8'h95,8'h96,8'hA0,8'hA1,8'hA2,8'hA4,8'hA5,8'hA6,8'hA9,8'hB0,8'hB1,8'hB4,
        8'hB5,8'hB6,8'hC0,8'hC1,8'hC4,8'hC5,8'hC6,8'hC9,8'hD0,8'hD1,8'hD5,8'hD6,8'hE0,8'hE1,
        8'hE4,8'hE5,8'hE6,8'hE9,8'hF0,8'hF1,8'hF5,8'hF6};
    logic [7:0] ops1 [29] = '{8'h00,8'h08,8'h0A,8'h18,8'h28,8'h2A,8'h38,8'h40,8'h48,8'h4A,
        8'h58,8'h60,8'h68,8'h6A,8'h78,8'h88,8'h8A,8'h98,8'h9A,8'hA8,8'hAA,8'hB8,8'hBA,8'hC8,
        8'hCA,8'hD8,8'hE8,8'hEA,8'hF8};

    function automatic bundle_t model(input logic [15:0] pc);
        bundle_t     b;
        logic [15:0] p1, p2;
        p1    = pc + 16'd1;
        p2    = pc + 16'd2;
        b.ir  = mem[pc];
        b.len = ref_len[b.ir];
        b.lo  = (b.len >= 2'd2) ? mem[p1] : 8'h00;
        b.hi  = (b.len == 2'd3) ? mem[p2] : 8'h00;
        b.pcn = pc + {14'd0, b.len};
`ifdef FETCH_ILLEGAL_TRAP_EN
        b.ill = ~ref_legal[b.ir];
`else
        b.ill = 1'b0;
`endif
        return b;
    endfunction

    // ---------------- scoreboard ----------------
    bundle_t exp_q[$];
    bundle_t act_b, snap_b, cur_b;
    logic [15:0] m_pc;
    int n_tests = 0;
    int n_fail  = 0;
    logic prev_v = 1'b0;

    assign act_b = {ir, opr_lo, opr_hi, len, pc_next, illegal_w};

    always @(negedge clk) begin
        bundle_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (instr_valid && !prev_v) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bundle_unexpected: got %h, none expected", act_b);
                end else begin
                    e = exp_q.pop_front();
                    if (act_b !== e) begin
                        n_fail++;
                        $display("FAIL bundle: got ir=%h lo=%h hi=%h len=%0d pcn=%h ill=%b, want ir=%h lo=%h hi=%h len=%0d pcn=%h ill=%b",
                                 act_b.ir, act_b.lo, act_b.hi, act_b.len, act_b.pcn, act_b.ill,
                                 e.ir, e.lo, e.hi, e.len, e.pcn, e.ill);
                    end
                end
                snap_b = act_b;
            end else if (instr_valid) begin
                n_tests++;
                if (act_b !== snap_b || mem_rd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h rd=%b, want %h rd=0", act_b, mem_rd, snap_b);
                end
            end
            prev_v = instr_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: no instr_valid after %0d cycles, want <= 40", n);
        end
    endtask

    // Called with rst high; releases reset and checks the first-valid cycle number.
    task automatic start_run(input int exp_cyc, input string nm);
        int n;
        exp_q.delete();
        m_pc  = {mem[16'hFFFD], mem[16'hFFFC]};
        cur_b = model(m_pc);
        exp_q.push_back(cur_b);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_valid(n);
        if (exp_cyc > 0) check(nm, n + 1, exp_cyc);
    endtask

    task automatic handshake(input logic load, input logic [15:0] tgt);
        instr_ready = 1'b1;
        pc_load     = load;
        pc_in       = tgt;
        m_pc        = load ? tgt : cur_b.pcn;
        cur_b       = model(m_pc);
        exp_q.push_back(cur_b);
        @(posedge clk); #1;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        pc_in       = 16'($urandom);
        check("fetch_addr", {16'd0, mem_addr}, {16'd0, m_pc});
        check("fetch_rd", {31'd0, mem_rd}, 32'd1);
    endtask

    task automatic wait_state(input fetch_state_t s, input string nm);
        int n;
        n = 0;
        while (dbg_state != s && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 32'(dbg_state), 32'(s));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        foreach (ref_len[i]) begin ref_len[i] = 2'd1; ref_legal[i] = 1'b0; end
        foreach (ops3[i]) begin ref_len[ops3[i]] = 2'd3; ref_legal[ops3[i]] = 1'b1; end
        foreach (ops2[i]) begin ref_len[ops2[i]] = 2'd2; ref_legal[ops2[i]] = 1'b1; end
        foreach (ops1[i]) ref_legal[ops1[i]] = 1'b1;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        // Reset values and reset-cycle outputs.
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12; mem[16'h1234] = 8'hEA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd",   {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
        check("rst_ir",       {24'd0, ir}, 32'hEA);
        check("rst_opr",      {16'd0, opr_hi, opr_lo}, 32'h0);
        check("rst_len",      {30'd0, len}, 32'd1);
        check("rst_pc",       {16'd0, pc_next}, 32'h0);
        check("rst_valid",    {31'd0, instr_valid}, 32'd0);
        check("rst_state",    32'(dbg_state), 32'(VEC_LO));
        start_run(6, "first_valid_len1");
        repeat (10) begin @(posedge clk); #1; end
        handshake(1'b0, 16'h0000);

        // Three-byte instruction.
        rst = 1'b1;
        mem[16'h1234] = 8'hAD; mem[16'h1235] = 8'h00; mem[16'h1236] = 8'h02;
        start_run(8, "first_valid_len3");
        handshake(1'b0, 16'h0000);

        // Redirect on handshake; pc_load and instr_ready outside VALID are ignored.
        rst = 1'b1;
        mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h05;
        mem[16'h8000] = 8'hA2; mem[16'h8001] = 8'h33;
        start_run(7, "first_valid_len2");
        handshake(1'b1, 16'h8000);
        wait_state(OPL, "reach_opl");
        pc_load = 1'b1; pc_in = 16'h4444; instr_ready = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0; instr_ready = 1'b0;
        wait_valid(n);
        handshake(1'b0, 16'h0000);

        // PC wrap past FFFF.
        rst = 1'b1;
        mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
        mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h07;
        start_run(7, "first_valid_wrap");
        handshake(1'b0, 16'h0000);

        // Reset in OPH, then a clean restart.
        rst = 1'b1;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'h8D; mem[16'h1235] = 8'h11; mem[16'h1236] = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        wait_state(OPH, "reach_oph");
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_state", 32'(dbg_state), 32'(VEC_LO));
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_rd",    {31'd0, mem_rd}, 32'd0);
        start_run(8, "restart_len3");

`ifdef FETCH_ILLEGAL_TRAP_EN
        rst = 1'b1;
        mem[16'h1234] = 8'h02;
        start_run(6, "first_valid_illegal");
        handshake(1'b0, 16'h0000);
`endif

        // Randomized program walk with stalls and redirects.
        rst = 1'b1;
        mem[16'hFFFC] = 8'($urandom); mem[16'hFFFD] = 8'($urandom);
        start_run(0, "");
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            handshake($urandom_range(0, 7) == 0, 16'($urandom));
            wait_valid(n);
            if (!instr_valid) break;
        end
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
